// File: rtl/por_seq_pkg.sv
// Shared types and default timing constants for the power-on-reset sequencer.
package por_seq_pkg;

  typedef enum logic [2:0] {
    ST_PDN      = 3'd0,
    ST_STARTUP  = 3'd1,
    ST_WAIT_PWR = 3'd2,
    ST_POR_WAIT = 3'd3,
    ST_SEQ      = 3'd4,
    ST_RUN      = 3'd5
  } por_state_e;

  localparam int DEF_NCH         = 4;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_STARTUP_CYC = 656;    // ~1 ms at 656 kHz
  localparam int DEF_POR_CYC     = 32800;  // ~50 ms at 656 kHz
  localparam int DEF_SHORT_CYC   = 16;
  localparam int DEF_DEB_CYC     = 8;

  // Terminal count of an up-counter that starts at 0 and must run len cycles.
  // A zero length behaves like a one-cycle timer.
  function automatic int term_cnt(input int len);
    return (len <= 0) ? 0 : len - 1;
  endfunction

endpackage

// File: rtl/por_deb.sv
// One supply channel: two-flop synchroniser followed by an asymmetric
// debouncer. A rising level is accepted only after DEB_CYC consecutive
// synchronised highs; a falling level is passed through without delay.
module por_deb
  import por_seq_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic osc_ck,
  input  logic rstb,
  input  logic pwup_async,
  output logic pwr_ok
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] DEB_TC = DW'(DEB_CYC);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Next-state for the synchroniser chain and the saturating high-run counter.
  always_comb begin
    sync1_d = pwup_async;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != DEB_TC) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers, cleared on reset so every channel starts as "not ok".
  always_ff @(posedge osc_ck or negedge rstb) begin
    if (!rstb) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gating with sync2_q makes loss of supply visible in the same cycle it
  // leaves the synchroniser, while acceptance waits for the full run.
  assign pwr_ok = sync2_q && (cnt_q == DEB_TC);

endmodule

// File: rtl/por_seq_ctrl.sv
// Power-on-reset sequencer: waits for oscillator startup and stable supplies,
// holds reset for the POR time, then releases per-channel resets in order.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_PDN      | block powered down, all resets asserted, oscillator off
// ST_STARTUP  | oscillator settling, startup timer running
// ST_WAIT_PWR | waiting for every debounced supply to be good
// ST_POR_WAIT | supplies good, POR hold timer running
// ST_SEQ      | releasing porb[0..NCH-1] one by one, seq_dly apart
// ST_RUN      | all channels released, watching for brownout
module por_seq_ctrl
  import por_seq_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STARTUP_CYC = DEF_STARTUP_CYC,
  parameter int POR_CYC     = DEF_POR_CYC,
  parameter int SHORT_CYC   = DEF_SHORT_CYC,
  parameter int DEB_CYC     = DEF_DEB_CYC
) (
  input  logic             osc_ck,
  input  logic             rstb,
  input  logic             force_pdn,
  input  logic             force_short_oneshot,
  input  logic [NCH-1:0]   pwup_filt,
  input  logic [CNT_W-1:0] seq_dly,
  output logic [NCH-1:0]   porb,
  output logic             osc_ena,
  output logic [2:0]       state_dbg,
  output logic             startup_timed_out,
  output logic             por_timed_out,
  output logic             brownout_evt,
  output logic [NCH-1:0]   fault_ch
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TC_STARTUP = CNT_W'(term_cnt(STARTUP_CYC));
  localparam logic [CNT_W-1:0] TC_POR     = CNT_W'(term_cnt(POR_CYC));
  localparam logic [CNT_W-1:0] TC_SHORT   = CNT_W'(term_cnt(SHORT_CYC));
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NCH - 1);

  logic [NCH-1:0] pwr_ok;
  logic           all_ok;

  por_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NCH-1:0]   porb_q, porb_d;
  logic             st_to_q, st_to_d;
  logic             por_to_q, por_to_d;
  logic             bo_q, bo_d;
  logic [NCH-1:0]   fault_q, fault_d;

  logic             use_short;
  logic [CNT_W-1:0] startup_tc;
  logic [CNT_W-1:0] por_tc;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] seq_dly_eff;

  for (genvar g = 0; g < NCH; g++) begin : g_deb
    por_deb #(
      .DEB_CYC(DEB_CYC)
    ) u_deb (
      .osc_ck    (osc_ck),
      .rstb      (rstb),
      .pwup_async(pwup_filt[g]),
      .pwr_ok    (pwr_ok[g])
    );
  end

  assign all_ok = &pwr_ok;

  // Timer helpers. The short/long choice is captured on the first cycle of a
  // timed state (counter still zero) and held for the rest of that interval.
  always_comb begin
    use_short   = (cnt_q == '0) ? force_short_oneshot : short_q;
    short_d     = use_short;
    startup_tc  = use_short ? TC_SHORT : TC_STARTUP;
    por_tc      = use_short ? TC_SHORT : TC_POR;
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    seq_dly_eff = (seq_dly == '0) ? CNT_W'(1) : seq_dly;
  end

  // Next-state and registered-output logic; power-down outranks brownout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    dly_d    = dly_q;
    idx_d    = idx_q;
    porb_d   = porb_q;
    st_to_d  = st_to_q;
    por_to_d = por_to_q;
    bo_d     = 1'b0;
    fault_d  = fault_q;

    if (force_pdn) begin
      state_d  = ST_PDN;
      cnt_d    = '0;
      idx_d    = '0;
      porb_d   = '0;
      st_to_d  = 1'b0;
      por_to_d = 1'b0;
      fault_d  = '0;
    end else if ((state_q == ST_SEQ || state_q == ST_RUN) && !all_ok) begin
      state_d  = ST_WAIT_PWR;
      cnt_d    = '0;
      idx_d    = '0;
      porb_d   = '0;
      por_to_d = 1'b0;
      bo_d     = 1'b1;
      fault_d  = fault_q | ~pwr_ok;
    end else begin
      unique case (state_q)
        ST_PDN: begin
          state_d = ST_STARTUP;
          cnt_d   = '0;
        end
        ST_STARTUP: begin
          if (cnt_q == startup_tc) begin
            state_d = ST_WAIT_PWR;
            st_to_d = 1'b1;
            cnt_d   = '0;
          end
        end
        ST_WAIT_PWR: begin
          cnt_d = '0;
          if (all_ok) begin
            state_d = ST_POR_WAIT;
          end
        end
        ST_POR_WAIT: begin
          if (!all_ok) begin
            state_d = ST_WAIT_PWR;
            cnt_d   = '0;
          end else if (cnt_q == por_tc) begin
            por_to_d = 1'b1;
            cnt_d    = '0;
            porb_d   = NCH'(1);
            idx_d    = IDX_W'(1);
            dly_d    = seq_dly_eff;
            state_d  = (NCH == 1) ? ST_RUN : ST_SEQ;
          end
        end
        ST_SEQ: begin
          if (cnt_q == dly_q - CNT_W'(1)) begin
            porb_d = porb_q | (NCH'(1) << idx_q);
            cnt_d  = '0;
            idx_d  = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_PDN;
          cnt_d   = '0;
          porb_d  = '0;
        end
      endcase
    end
  end

  // State registers; reset lands directly in PDN if power-down is requested.
  always_ff @(posedge osc_ck or negedge rstb) begin
    if (!rstb) begin
      state_q  <= force_pdn ? ST_PDN : ST_STARTUP;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      dly_q    <= '0;
      idx_q    <= '0;
      porb_q   <= '0;
      st_to_q  <= 1'b0;
      por_to_q <= 1'b0;
      bo_q     <= 1'b0;
      fault_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      dly_q    <= dly_d;
      idx_q    <= idx_d;
      porb_q   <= porb_d;
      st_to_q  <= st_to_d;
      por_to_q <= por_to_d;
      bo_q     <= bo_d;
      fault_q  <= fault_d;
    end
  end

  assign porb              = porb_q;
  assign osc_ena           = ~force_pdn;
  assign state_dbg         = state_q;
  assign startup_timed_out = st_to_q;
  assign por_timed_out     = por_to_q;
  assign brownout_evt      = bo_q;
  assign fault_ch          = fault_q;

endmodule

// File: tb/tb_por_seq_ctrl.sv
// Directed bench for por_seq_ctrl with default parameters (NCH=4, DEB_CYC=8,
// SHORT_CYC=16, STARTUP_CYC=656). Inputs change and outputs are sampled on
// the falling edge; "edge N" below counts rising edges after reset release.
module tb_por_seq_ctrl;
  import por_seq_pkg::*;

  logic        osc_ck = 1'b0;
  logic        rstb;
  logic        force_pdn;
  logic        force_short_oneshot;
  logic [3:0]  pwup_filt;
  logic [15:0] seq_dly;
  logic [3:0]  porb;
  logic        osc_ena;
  logic [2:0]  state_dbg;
  logic        startup_timed_out;
  logic        por_timed_out;
  logic        brownout_evt;
  logic [3:0]  fault_ch;

  int n_checks = 0;
  int n_errors = 0;

  por_seq_ctrl dut (
    .osc_ck             (osc_ck),
    .rstb               (rstb),
    .force_pdn          (force_pdn),
    .force_short_oneshot(force_short_oneshot),
    .pwup_filt          (pwup_filt),
    .seq_dly            (seq_dly),
    .porb               (porb),
    .osc_ena            (osc_ena),
    .state_dbg          (state_dbg),
    .startup_timed_out  (startup_timed_out),
    .por_timed_out      (por_timed_out),
    .brownout_evt       (brownout_evt),
    .fault_ch           (fault_ch)
  );

  always #5 osc_ck = ~osc_ck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge osc_ck);
  endtask

  task automatic wait_state(input logic [2:0] st, input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc && state_dbg != st; i++) @(negedge osc_ck);
    chk(tag, 32'(state_dbg), 32'(st));
  endtask

  initial begin
    logic saw_por_wait;

    rstb                = 1'b0;
    force_pdn           = 1'b1;
    force_short_oneshot = 1'b1;
    pwup_filt           = 4'hF;
    seq_dly             = 16'd4;

    // Reset with power-down requested, then without.
    adv(1);
    chk("rst_pdn_state", 32'(state_dbg), 32'(ST_PDN));
    chk("rst_pdn_osc", 32'(osc_ena), 32'h0);
    chk("rst_pdn_porb", 32'(porb), 32'h0);
    force_pdn = 1'b0;
    #1 chk("osc_ena_comb", 32'(osc_ena), 32'h1);
    adv(1);
    chk("rst_state", 32'(state_dbg), 32'(ST_STARTUP));
    chk("rst_porb", 32'(porb), 32'h0);
    chk("rst_flags", 32'({startup_timed_out, por_timed_out, brownout_evt}), 32'h0);
    chk("rst_fault", 32'(fault_ch), 32'h0);
    rstb = 1'b1;

    // Short timers, seq_dly=4: startup at edge 16, POR_WAIT at 17, SEQ at 33.
    adv(15);
    chk("startup_early", 32'(startup_timed_out), 32'h0);
    adv(1);
    chk("startup_16", 32'(startup_timed_out), 32'h1);
    chk("state_wait_pwr", 32'(state_dbg), 32'(ST_WAIT_PWR));
    adv(1);
    chk("state_por_wait", 32'(state_dbg), 32'(ST_POR_WAIT));
    adv(15);
    chk("por_early", 32'(por_timed_out), 32'h0);
    chk("porb_held", 32'(porb), 32'h0);
    adv(1);
    chk("por_16", 32'(por_timed_out), 32'h1);
    chk("state_seq", 32'(state_dbg), 32'(ST_SEQ));
    chk("porb_ch0", 32'(porb), 32'h1);
    adv(3);
    chk("porb_ch0_hold", 32'(porb), 32'h1);
    adv(1);
    chk("porb_ch1", 32'(porb), 32'h3);
    adv(4);
    chk("porb_ch2", 32'(porb), 32'h7);
    adv(4);
    chk("porb_ch3", 32'(porb), 32'hF);
    chk("state_run", 32'(state_dbg), 32'(ST_RUN));

    // One-cycle dip on channel 2 in RUN (edge 50 onward).
    adv(5);
    pwup_filt[2] = 1'b0;
    adv(1);
    pwup_filt[2] = 1'b1;
    adv(1);
    chk("bo_porb_before", 32'(porb), 32'hF);
    adv(1);
    chk("bo_porb", 32'(porb), 32'h0);
    chk("bo_evt", 32'(brownout_evt), 32'h1);
    chk("bo_fault", 32'(fault_ch), 32'h4);
    chk("bo_state", 32'(state_dbg), 32'(ST_WAIT_PWR));
    chk("bo_por_clr", 32'(por_timed_out), 32'h0);
    chk("bo_startup_kept", 32'(startup_timed_out), 32'h1);
    adv(1);
    chk("bo_pulse_end", 32'(brownout_evt), 32'h0);
    adv(7);
    chk("redeb_wait", 32'(state_dbg), 32'(ST_WAIT_PWR));
    adv(1);
    chk("redeb_por_wait", 32'(state_dbg), 32'(ST_POR_WAIT));

    // Channel 1 drops in POR_WAIT (quiet return), then glitches high 5 cycles.
    pwup_filt[1] = 1'b0;
    adv(3);
    chk("porw_drop_state", 32'(state_dbg), 32'(ST_WAIT_PWR));
    chk("porw_drop_no_bo", 32'(brownout_evt), 32'h0);
    chk("fault_sticky", 32'(fault_ch), 32'h4);
    adv(1);
    pwup_filt[1] = 1'b1;
    adv(5);
    pwup_filt[1] = 1'b0;
    saw_por_wait = 1'b0;
    for (int i = 0; i < 15; i++) begin
      adv(1);
      if (state_dbg == ST_POR_WAIT) saw_por_wait = 1'b1;
    end
    chk("glitch_rejected", 32'(saw_por_wait), 32'h0);
    pwup_filt[1] = 1'b1;

    // Power-down together with a brownout in mid-SEQ.
    wait_state(ST_SEQ, 200, "reach_seq");
    chk("seq2_porb", 32'(porb), 32'h1);
    adv(1);
    pwup_filt[0] = 1'b0;
    adv(2);
    chk("pdn_pre_state", 32'(state_dbg), 32'(ST_SEQ));
    force_pdn = 1'b1;
    #1 chk("pdn_osc_off", 32'(osc_ena), 32'h0);
    adv(1);
    chk("pdn_state", 32'(state_dbg), 32'(ST_PDN));
    chk("pdn_porb", 32'(porb), 32'h0);
    chk("pdn_no_bo", 32'(brownout_evt), 32'h0);
    chk("pdn_fault_clr", 32'(fault_ch), 32'h0);
    chk("pdn_flags_clr", 32'({startup_timed_out, por_timed_out}), 32'h0);
    adv(2);
    chk("pdn_hold", 32'(state_dbg), 32'(ST_PDN));
    force_pdn    = 1'b0;
    pwup_filt[0] = 1'b1;
    adv(1);
    chk("pdn_exit", 32'(state_dbg), 32'(ST_STARTUP));

    // Asynchronous reset in RUN, restart with seq_dly=0 (1-cycle spacing).
    wait_state(ST_RUN, 300, "reach_run");
    #2 rstb = 1'b0;
    #1;
    chk("arst_porb", 32'(porb), 32'h0);
    chk("arst_state", 32'(state_dbg), 32'(ST_STARTUP));
    chk("arst_flags", 32'({startup_timed_out, por_timed_out, brownout_evt}), 32'h0);
    seq_dly = 16'd0;
    adv(1);
    rstb = 1'b1;
    adv(16);
    chk("re_startup", 32'(startup_timed_out), 32'h1);
    adv(1);
    chk("re_por_wait", 32'(state_dbg), 32'(ST_POR_WAIT));
    adv(16);
    chk("re_porb0", 32'(porb), 32'h1);
    adv(1);
    chk("re_porb1", 32'(porb), 32'h3);
    adv(1);
    chk("re_porb2", 32'(porb), 32'h7);
    adv(1);
    chk("re_porb3", 32'(porb), 32'hF);
    chk("re_run", 32'(state_dbg), 32'(ST_RUN));

    // Long startup timer; length is latched at timer start.
    force_pdn = 1'b1;
    adv(1);
    force_short_oneshot = 1'b0;
    force_pdn           = 1'b0;
    adv(1);
    chk("long_start", 32'(state_dbg), 32'(ST_STARTUP));
    adv(1);
    force_short_oneshot = 1'b1;
    adv(654);
    chk("long_early", 32'(startup_timed_out), 32'h0);
    adv(1);
    chk("long_656", 32'(startup_timed_out), 32'h1);
    chk("long_state", 32'(state_dbg), 32'(ST_WAIT_PWR));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
